randgen_stream: RTL and testbench

RANDGEN_STREAM -- requirements
Module: randgen_stream

---
 rtl/randgen_stream.sv | 109 ++++++++++
 tb/tb_randgen_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/randgen_stream.sv
// rtl/randgen_stream.sv - xorshift128+ multi-lane pseudo-random word stream with valid/ready handshake
module randgen_stream #(
  parameter int          N          = 2048,
  parameter logic [63:0] SEED       = 64'h0,
  parameter bit          ZERO_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          seed_load,
  input  logic [63:0]   seed_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  data_out,
  output logic [31:0]   word_count
);

  localparam int L = (N + 127) / 128;
  localparam int W = L * 128;

  typedef enum logic [1:0] {LOAD, RUN, PAUSE} state_t;

  state_t       state;
  logic [63:0]  seed_reg;
  logic [W-1:0] lanes;
  logic [W-1:0] init_vec;
  logic [W-1:0] next_vec;
  logic [W-1:0] word_raw;
  logic [31:0]  wcnt;
  logic         handshake;

  // One xorshift128+ step; s is the low half, t the high half of a lane.
  function automatic logic [127:0] xs_step(input logic [127:0] lane);
    logic [63:0] s;
    logic [63:0] t;
    s = lane[63:0];
    t = lane[127:64];
    t = t ^ (t << 23);
    t = t ^ (t >> 17);
    t = t ^ s ^ (s >> 26);
    return {s, t};
  endfunction

  // Per-lane start values (seed in the upper half, lane index+1 below so no lane is zero) and next states.
  always_comb begin
    init_vec = '0;
    next_vec = '0;
    for (int k = 0; k < L; k++) begin
      init_vec[k*128 +: 128] = {seed_reg, 64'(k + 1)};
      next_vec[k*128 +: 128] = xs_step(lanes[k*128 +: 128]);
    end
  end

  assign word_raw   = ZERO_FIRST ? (lanes ^ init_vec) : lanes;
  assign data_out   = out_valid ? word_raw[N-1:0] : '0;
  assign word_count = wcnt;
  assign handshake  = out_valid & out_ready;

  // Control FSM: reseed has priority over everything, including a pending handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      seed_reg  <= SEED;
      lanes     <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
    end else if (seed_load) begin
      seed_reg  <= seed_in;
      state     <= LOAD;
      out_valid <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (state)
        LOAD: begin
          lanes <= init_vec;
          wcnt  <= '0;
          if (enable) begin
            state     <= RUN;
            out_valid <= 1'b1;
          end else begin
            state     <= PAUSE;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (handshake) begin
            lanes <= next_vec;
            if (wcnt != 32'hFFFF_FFFF) wcnt <= wcnt + 32'd1;
            if (!enable) begin
              state     <= PAUSE;
              out_valid <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (enable) begin
            state     <= RUN;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= LOAD;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_randgen_stream.sv
// tb/tb_randgen_stream.sv - self-checking bench for randgen_stream
module tb_randgen_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable;
  logic          seed_load;
  logic [63:0]   seed_in;
  logic          out_ready;

  logic          va;
  logic [127:0]  da;
  logic [31:0]   wca;
  logic          vb;
  logic [299:0]  db;
  logic [31:0]   wcb;

  randgen_stream #(.N(128), .SEED(64'h0), .ZERO_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .out_valid(va), .out_ready(out_ready), .data_out(da), .word_count(wca)
  );

  randgen_stream #(.N(300), .SEED(64'h0), .ZERO_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .seed_load(seed_load), .seed_in(seed_in),
    .out_valid(vb), .out_ready(out_ready), .data_out(db), .word_count(wcb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [127:0] sb[$];
  logic [127:0] m_lane;
  logic [127:0] m_init;

  typedef struct {
    logic        rdy;
    logic        en;
    logic        ev;
    logic [31:0] ewc;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [127:0] model_step(input logic [127:0] l);
    logic [63:0] s;
    logic [63:0] t;
    s = l[63:0];
    t = l[127:64];
    t = t ^ (t << 23);
    t = t ^ (t >> 17);
    t = t ^ s ^ (s >> 26);
    return {s, t};
  endfunction

  task automatic model_reset(input logic [63:0] seed);
    m_init = {seed, 64'd1};
    m_lane = m_init;
  endtask

  task automatic model_push(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(m_lane ^ m_init);
      m_lane = model_step(m_lane);
    end
  endtask

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_pop_chk(input string name);
    logic [127:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got word %h expected none (scoreboard empty)", name, da);
    end else begin
      e = sb.pop_front();
      chk(name, {172'd0, da}, {172'd0, e});
    end
  endtask

  task automatic sb_peek_chk(input string name);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got word %h expected none (scoreboard empty)", name, da);
    end else begin
      chk(name, {172'd0, da}, {172'd0, sb[0]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [299:0] eb;
    int k;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 32'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'd3};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd3};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'd4};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'd4};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'd4};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'd5};

    eb = '0;
    eb[63:0]    = 64'd1;
    eb[191:128] = 64'd2;
    eb[299:256] = 44'd3;

    rst_n     = 1'b0;
    enable    = 1'b1;
    seed_load = 1'b0;
    seed_in   = 64'h0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {299'd0, va}, 300'd0);
    chk("reset_data", {172'd0, da}, 300'd0);
    chk("reset_count", {268'd0, wca}, 300'd0);

    model_reset(64'h0);
    model_push(6);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      out_ready = tbl[i].rdy;
      enable    = tbl[i].en;
      #1;
      chk($sformatf("tbl%0d_valid", i), {299'd0, va}, {299'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_count", i), {268'd0, wca}, {268'd0, tbl[i].ewc});
      if (tbl[i].ev) begin
        if (tbl[i].rdy) sb_pop_chk($sformatf("tbl%0d_word", i));
        else            sb_peek_chk($sformatf("tbl%0d_hold", i));
      end else begin
        chk($sformatf("tbl%0d_zero", i), {172'd0, da}, 300'd0);
      end
      if (i == 1) chk("n300_first_word", db, eb);
    end

    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 64'hDEAD_BEEF;
    out_ready = 1'b1;
    enable    = 1'b1;
    #1;
    chk("reseed_pre_valid", {299'd0, va}, 300'd1);
    chk("reseed_pre_count", {268'd0, wca}, 300'd6);
    @(negedge clk);
    seed_load = 1'b0;
    #1;
    chk("reseed_gap_valid", {299'd0, va}, 300'd0);
    chk("reseed_gap_count", {268'd0, wca}, 300'd0);
    chk("reseed_gap_data", {172'd0, da}, 300'd0);
    sb.delete();
    model_reset(64'hDEAD_BEEF);
    model_push(6);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reseed%0d_valid", i), {299'd0, va}, 300'd1);
      chk($sformatf("reseed%0d_count", i), {268'd0, wca}, {268'd0, 32'(i)});
      if (i == 0) chk("reseed_first_zero", {172'd0, da}, 300'd0);
      sb_pop_chk($sformatf("reseed%0d_word", i));
    end

    model_push(3);
    @(negedge clk);
    force dut_a.wcnt = 32'hFFFF_FFFE;
    #1;
    release dut_a.wcnt;
    chk("sat_forced", {268'd0, wca}, {268'd0, 32'hFFFF_FFFE});
    sb_pop_chk("sat_word0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) out_ready = 1'b0;
      #1;
      chk($sformatf("sat%0d_count", i), {268'd0, wca}, {268'd0, 32'hFFFF_FFFF});
      if (i < 2) sb_pop_chk($sformatf("sat%0d_word", i + 1));
    end

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {299'd0, va}, 300'd0);
    chk("midreset_data", {172'd0, da}, 300'd0);
    chk("midreset_count", {268'd0, wca}, 300'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    model_reset(64'h0);
    model_push(2);
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!va && k < 10);
    chk("restart_valid", {299'd0, va}, 300'd1);
    if (va) begin
      sb_pop_chk("restart_word0");
      @(negedge clk);
      #1;
      sb_pop_chk("restart_word1");
      chk("restart_count", {268'd0, wca}, 300'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
